bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter.sv | 113 +++++++++++
 tb/tb_bus_arbiter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// Round-robin, non-preemptive bus arbiter: one granted master at a time drives the
// shared slave port; the slave response is passed straight back with no added latency.
module bus_arbiter #(
  parameter int NMASTERS = 3,
  localparam int GW = (NMASTERS > 2) ? $clog2(NMASTERS) : 1
) (
  input  logic                     clk,
  input  logic                     rst_b,
  input  logic [NMASTERS-1:0]      m_req,
  output logic [NMASTERS-1:0]      m_ack,
  input  logic [32*NMASTERS-1:0]   m_addr,
  input  logic [32*NMASTERS-1:0]   m_wdata,
  input  logic [NMASTERS-1:0]      m_rd,
  input  logic [NMASTERS-1:0]      m_wr,
  output logic [31:0]              m_rdata,
  output logic [NMASTERS-1:0]      m_ready,
  output logic [31:0]              s_addr,
  output logic [31:0]              s_wdata,
  output logic                     s_rd,
  output logic                     s_wr,
  input  logic [31:0]              s_rdata,
  input  logic                     s_ready,
  output logic                     dbg_state,
  output logic [GW-1:0]            dbg_ptr
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [GW-1:0]       g_q, g_d;
  logic [GW-1:0]       p_q, p_d;
  logic [NMASTERS-1:0] others;

  // First requester at or after start, wrapping modulo NMASTERS so a
  // non-power-of-two count never yields a nonexistent master.
  function automatic logic [GW-1:0] pick(input logic [GW-1:0] start,
                                         input logic [NMASTERS-1:0] req);
    logic found;
    int   idx;
    pick  = start;
    found = 1'b0;
    for (int k = 0; k < NMASTERS; k++) begin
      idx = (int'(start) + k) % NMASTERS;
      if (!found && req[idx]) begin
        pick  = GW'(idx);
        found = 1'b1;
      end
    end
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_q <= IDLE;
      g_q     <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      p_q     <= p_d;
    end
  end

  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    p_d     = p_q;
    others  = '0;
    case (state_q)
      IDLE: begin
        if (|m_req) begin
          g_d     = pick(p_q, m_req);
          state_d = GRANT;
        end
      end
      GRANT: begin
        // The grant is held while the owner keeps requesting; on release the
        // owner itself is masked out so the hand-over goes to someone else.
        if (!m_req[g_q]) begin
          p_d    = (g_q == GW'(NMASTERS - 1)) ? '0 : g_q + GW'(1);
          others = m_req & ~(NMASTERS'(1) << g_q);
          if (|others) g_d = pick(p_d, others);
          else         state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    m_ack   = '0;
    s_addr  = '0;
    s_wdata = '0;
    s_rd    = 1'b0;
    s_wr    = 1'b0;
    for (int i = 0; i < NMASTERS; i++) begin
      if (state_q == GRANT && g_q == GW'(i)) begin
        m_ack[i] = 1'b1;
        if (m_req[i]) begin
          s_addr  = m_addr[32*i +: 32];
          s_wdata = m_wdata[32*i +: 32];
          s_wr    = m_wr[i];
          s_rd    = m_rd[i] & ~m_wr[i];
        end
      end
    end
  end

  assign m_ready   = m_ack & {NMASTERS{s_ready}};
  assign m_rdata   = s_rdata;
  assign dbg_state = (state_q == GRANT);
  assign dbg_ptr   = p_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter (3 masters): expected outputs are queued per cycle
// as stimulus is driven and drained against the DUT on the falling edge.
module tb_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_b;
  logic [2:0]  m_req, m_ack, m_rd, m_wr, m_ready;
  logic [95:0] m_addr, m_wdata;
  logic [31:0] m_rdata, s_addr, s_wdata, s_rdata;
  logic        s_rd, s_wr, s_ready, dbg_state;
  logic [1:0]  dbg_ptr;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];

  bus_arbiter #(.NMASTERS(3)) dut (
    .clk(clk), .rst_b(rst_b), .m_req(m_req), .m_ack(m_ack), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_rd(m_rd), .m_wr(m_wr), .m_rdata(m_rdata),
    .m_ready(m_ready), .s_addr(s_addr), .s_wdata(s_wdata), .s_rd(s_rd),
    .s_wr(s_wr), .s_rdata(s_rdata), .s_ready(s_ready),
    .dbg_state(dbg_state), .dbg_ptr(dbg_ptr)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic logic [31:0] observe(input string t);
    case (t)
      "ack":    return {29'b0, m_ack};
      "rdy":    return {29'b0, m_ready};
      "saddr":  return s_addr;
      "swdata": return s_wdata;
      "srd":    return {31'b0, s_rd};
      "swr":    return {31'b0, s_wr};
      "rdata":  return m_rdata;
      "state":  return {31'b0, dbg_state};
      "ptr":    return {30'b0, dbg_ptr};
      default:  return 32'hxxxx_xxxx;
    endcase
  endfunction

  task automatic push_exp(input string tag, input logic [31:0] v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  task automatic settle();
    string       t;
    logic [31:0] e;
    @(negedge clk);
    while (exp_q.size() > 0) begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      check_val(t, observe(t), e);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] addr0, a1;
  logic [2:0]  onehot;

  initial begin
    rst_b = 1'b0; m_req = '0; m_rd = '0; m_wr = '0;
    m_addr = '0; m_wdata = '0; s_rdata = '0; s_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    push_exp("ack", 0); push_exp("srd", 0); push_exp("swr", 0); push_exp("saddr", 0);
    push_exp("swdata", 0); push_exp("rdy", 0); push_exp("state", 0); push_exp("ptr", 0);
    settle();

    // Single read by DCache
    next_cycle();
    rst_b = 1'b1; m_req = 3'b010; m_rd = 3'b010; m_addr[63:32] = 32'h1000;
    push_exp("ack", 0); push_exp("state", 0);
    settle();
    next_cycle();
    s_rdata = $urandom;
    push_exp("ack", 3'b010); push_exp("saddr", 32'h1000); push_exp("srd", 1);
    push_exp("swr", 0); push_exp("rdy", 3'b010); push_exp("rdata", s_rdata);
    push_exp("state", 1);
    settle();
    next_cycle();
    m_req = 3'b000;
    push_exp("ack", 3'b010); push_exp("saddr", 0); push_exp("srd", 0); push_exp("rdy", 3'b010);
    settle();
    next_cycle();
    push_exp("ack", 0); push_exp("state", 0); push_exp("ptr", 2); push_exp("rdy", 0);
    settle();
    next_cycle();
    push_exp("state", 0); push_exp("ptr", 2);
    settle();

    // Two requesters from reset, back-to-back hand-over
    next_cycle();
    rst_b = 1'b0; m_req = 3'b011; m_rd = 3'b000;
    settle();
    next_cycle();
    rst_b = 1'b1;
    push_exp("ack", 0); push_exp("state", 0); push_exp("ptr", 0);
    settle();
    next_cycle();
    push_exp("ack", 3'b001); push_exp("state", 1);
    settle();
    next_cycle();
    m_req = 3'b010;
    push_exp("ack", 3'b001);
    settle();
    next_cycle();
    push_exp("ack", 3'b010); push_exp("state", 1); push_exp("ptr", 1);
    settle();

    // 16-beat DCache fill while ICache keeps requesting with junk command
    addr0 = $urandom_range(32'h0000_0100, 32'h0000_0fff);
    m_addr[31:0] = addr0; m_wdata[31:0] = $urandom;
    m_rd = 3'b011; m_wr = 3'b001; m_req = 3'b011;
    for (int k = 0; k < 32; k++) begin
      next_cycle();
      s_ready = k[0];
      a1 = 32'h3000 + 32'(4 * (k / 2));
      m_addr[63:32] = a1;
      push_exp("ack", 3'b010); push_exp("rdy", s_ready ? 3'b010 : 3'b000);
      push_exp("srd", 1); push_exp("swr", 0); push_exp("saddr", a1);
      settle();
    end
    next_cycle();
    m_req = 3'b001; s_ready = 1'b0;
    push_exp("ack", 3'b010); push_exp("srd", 0); push_exp("saddr", 0);
    settle();
    next_cycle();
    push_exp("ack", 3'b001); push_exp("ptr", 2); push_exp("state", 1);
    push_exp("swr", 1); push_exp("srd", 0); push_exp("saddr", addr0);
    settle();

    // Reset in the middle of a granted write by master 2
    next_cycle();
    m_req = 3'b100; m_wr = 3'b100; m_rd = 3'b000; s_ready = 1'b1;
    m_addr[95:64] = 32'h2004; m_wdata[95:64] = 32'hDEADBEEF;
    push_exp("ack", 3'b001); push_exp("swr", 0); push_exp("saddr", 0);
    settle();
    next_cycle();
    push_exp("ack", 3'b100); push_exp("swr", 1); push_exp("srd", 0); push_exp("saddr", 32'h2004);
    push_exp("swdata", 32'hDEADBEEF); push_exp("rdy", 3'b100); push_exp("ptr", 1);
    settle();
    next_cycle();
    rst_b = 1'b0;
    push_exp("ack", 3'b100); push_exp("swr", 1);
    settle();
    next_cycle();
    push_exp("swr", 0); push_exp("ack", 0); push_exp("saddr", 0); push_exp("swdata", 0);
    push_exp("rdy", 0); push_exp("state", 0); push_exp("ptr", 0);
    m_req = 3'b111; m_wr = 3'b000;
    settle();

    // Three masters contending, each releasing after two granted cycles
    next_cycle();
    rst_b = 1'b1;
    push_exp("ack", 0); push_exp("state", 0);
    settle();
    next_cycle();
    for (int j = 0; j < 6; j++) begin
      onehot = 3'b001 << (j % 3);
      push_exp("ack", onehot);
      settle();
      next_cycle();
      push_exp("ack", onehot);
      settle();
      next_cycle();
      m_req = 3'b111 & ~onehot;
      push_exp("ack", onehot);
      settle();
      next_cycle();
      m_req = 3'b111;
    end
    push_exp("ack", 3'b001); push_exp("state", 1); push_exp("ptr", 0);
    settle();

    // Read and write both asserted: write wins
    m_rd = 3'b001; m_wr = 3'b001; m_addr[31:0] = 32'h44; m_wdata[31:0] = 32'h12345678;
    push_exp("swr", 1); push_exp("srd", 0); push_exp("saddr", 32'h44);
    push_exp("swdata", 32'h12345678);
    settle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
